mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data BRAM between three requesters: 0 = instruction fetch, 1 = data fetch load, 2 = data fetch store.
- Uses round-robin arbitration with a burst lock and a maximum-burst starvation guard.
- Tags each read beat with its owner and returns read-valid to that owner only, after a fixed memory latency.
- Sits between the control unit's fetch/store datapath and the memory macro.

Parameters:
- N_REQ, 3, number of requesters (supported range 2..4).
- ADDR_W, 17, memory address width.
- DATA_W, 32, memory data width.
- RD_LAT, 2, memory read latency in cycles (1..4).
- MAX_BURST, 16, maximum consecutive beats while another requester waits.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset; synchronous, active-high.
- REQ  in  N_REQ  per-requester request; held high for the whole burst.
- REQ_WE  in  N_REQ  per-requester write enable for the current beat.
- REQ_ADDR  in  N_REQ*ADDR_W  packed addresses; requester i uses slice i.
- REQ_WDATA  in  N_REQ*DATA_W  packed write data.
- GNT  out  N_REQ  one-hot grant, registered.
- RVALID  out  N_REQ  read data valid, per requester.
- RDATA  out  DATA_W  read data broadcast from memory.
- MEM_EN  out  1  memory enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_RDATA  in  DATA_W  memory read data, valid RD_LAT cycles after a read beat.
- BUSY  out  1  high when GNT != 0 or any read is in flight.

Behaviour:
- Reset values:
  - GNT = 0, RVALID = 0, BUSY = 0, MEM_EN = 0, MEM_WE = 0.
  - MEM_ADDR = 0 and MEM_WDATA = 0 while no grant is active.
  - RR pointer = N_REQ-1, so requester 0 wins first; beat counter = 0; tag pipeline cleared.
- Reset mid-burst or with reads in flight: grant drops next cycle. In-flight tags are discarded; RVALID must not fire for them.
- FSM has three states:
  - IDLE: if any REQ, pick the first requester with REQ high, searching from pointer+1 with wrap. Register the one-hot GNT and go to OWN. GNT appears the cycle after REQ is sampled (1-cycle grant latency).
  - OWN: each cycle with GNT[i] & REQ[i] is one beat.
    - MEM_EN = 1; MEM_WE / MEM_ADDR / MEM_WDATA come combinationally from requester i.
    - The beat counter increments each beat.
  - OWN exits:
    - REQ[i] low: no beat; GNT clears next cycle; pointer = i; go to IDLE.
    - Counter reaches MAX_BURST with another REQ pending: GNT clears; pointer = i; go to SWITCH.
    - Counter reaches MAX_BURST with no other REQ pending: the counter resets and OWN continues.
    - If REQ drops in the same cycle the cap is hit, the release path is taken.
  - SWITCH: one dead cycle with MEM_EN = 0, then arbitrate as in IDLE. A requester that was just preempted is eligible but last in order.
- Read tagging: each read beat (MEM_WE = 0) pushes {1, owner} into an RD_LAT-deep shift register. At the output, RVALID[owner] = 1 for exactly one cycle, aligned with MEM_RDATA. RDATA = MEM_RDATA unregistered.
- Reads keep returning after a grant change. RVALID to the old owner is still delivered while the new owner issues beats.
- Write beats push an invalid tag.
- BUSY = |GNT | (any valid tag in the pipeline).
- REQ_WE on a non-granted requester is ignored.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output STAT_GRANTS (N_REQ*16): per-requester count of beats.
  - Adds output STAT_WAIT (N_REQ*16): per-requester count of cycles with REQ high and GNT low.
  - All counters are saturating at 16'hFFFF and cleared on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, OWN, SWITCH};
  - requester index constants REQ_IF = 0, REQ_LD = 1, REQ_ST = 2;
  - typedef rd_tag_t {valid, owner}.
- One sub-module, rr_pick: combinational round-robin selector. Inputs: request vector and pointer. Output: one-hot grant.

Test Plan:
- REQ = 3'b010 held for 4 cycles, reads at addresses 5..8, RD_LAT = 2 -> GNT = 010 next cycle; four MEM_EN beats; RVALID[1] pulses on 4 consecutive cycles, 2 cycles after each beat.
- REQ = 3'b111 asserted together after reset -> grant order 0, 1, 2, with one IDLE cycle between each release.
- REQ[0] held for 40 beats, REQ[2] high from cycle 3, MAX_BURST = 16 -> GNT[0] drops after beat 16; SWITCH dead cycle; GNT[2] granted; requester 0 regranted after requester 2 releases.
- Requester 1 reads at address 9, then releases; requester 2 writes on the next grant -> RVALID[1] pulses during requester 2's write beats; RVALID[2] never asserts.
- RSTN asserted during OWN with 2 reads in flight -> GNT = 0 and BUSY = 0 the next cycle; no RVALID afterwards.
- ARB_STATS_EN defined, REQ[1] waits 3 cycles then does 5 beats -> STAT_WAIT[1] = 3 and STAT_GRANTS[1] = 5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, SWITCH} arb_state_t;

  localparam int unsigned REQ_IF  = 0;
  localparam int unsigned REQ_LD  = 1;
  localparam int unsigned REQ_ST  = 2;
  localparam int unsigned OWNER_W = 2;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } rd_tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first request after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o
);

  localparam int unsigned PTR_W = $clog2(N);

  logic [PTR_W-1:0] idx;

  // Walk from the farthest offset down so the nearest requester after ptr_i wins.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = PTR_W'((32'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin single-port BRAM arbiter with burst lock, burst cap and read tagging.
// Define ARB_STATS_EN to add per-requester beat and wait counters.
module mem_port_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         REQ_WE,
  input  logic [N_REQ*ADDR_W-1:0]  REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0]  REQ_WDATA,
  output logic [N_REQ-1:0]         GNT,
  output logic [N_REQ-1:0]         RVALID,
  output logic [DATA_W-1:0]        RDATA,
  output logic                     MEM_EN,
  output logic                     MEM_WE,
  output logic [ADDR_W-1:0]        MEM_ADDR,
  output logic [DATA_W-1:0]        MEM_WDATA,
  input  logic [DATA_W-1:0]        MEM_RDATA,
  output logic                     BUSY
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]      STAT_GRANTS,
  output logic [N_REQ*16-1:0]      STAT_WAIT
`endif
);

  import mem_arb_pkg::*;

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  rd_tag_t          tag_q [RD_LAT];

  logic [N_REQ-1:0]  pick;
  logic [PTR_W-1:0]  own_idx;
  logic              req_own, others, beat, tag_busy;
  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];
  rd_tag_t           tag_out;

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    own_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addr_a[i]  = REQ_ADDR[i*ADDR_W +: ADDR_W];
      wdata_a[i] = REQ_WDATA[i*DATA_W +: DATA_W];
      if (gnt_q[i]) own_idx = PTR_W'(i);
    end
  end

  assign req_own = |(gnt_q & REQ);
  assign others  = |(REQ & ~gnt_q);
  // A beat landing in a reset cycle must not reach the macro.
  assign beat    = req_own & ~RSTN;

  assign GNT       = gnt_q;
  assign MEM_EN    = beat;
  assign MEM_WE    = beat & REQ_WE[own_idx];
  assign MEM_ADDR  = (|gnt_q) ? addr_a[own_idx]  : '0;
  assign MEM_WDATA = (|gnt_q) ? wdata_a[own_idx] : '0;
  assign RDATA     = MEM_RDATA;

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, SWITCH: begin
          cnt_q <= '0;
          if (|REQ) begin
            gnt_q   <= pick;
            state_q <= OWN;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN: begin
          // Release has priority over the burst cap when both happen together.
          if (!req_own) begin
            gnt_q   <= '0;
            ptr_q   <= own_idx;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            cnt_q <= '0;
            if (others) begin
              gnt_q   <= '0;
              ptr_q   <= own_idx;
              state_q <= SWITCH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: beat & ~MEM_WE, owner: OWNER_W'(own_idx)};
      for (int unsigned i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  always_comb begin
    RVALID   = '0;
    tag_busy = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++)
      RVALID[i] = tag_out.valid & (tag_out.owner == OWNER_W'(i)) & ~RSTN;
    for (int unsigned i = 0; i < RD_LAT; i++)
      tag_busy = tag_busy | tag_q[i].valid;
  end

  assign BUSY = (|gnt_q) | tag_busy;

`ifdef ARB_STATS_EN
  logic [15:0] grants_q [N_REQ];
  logic [15:0] wait_q   [N_REQ];

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        grants_q[i] <= '0;
        wait_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (gnt_q[i] & REQ[i]) grants_q[i] <= sat_inc16(grants_q[i]);
        if (REQ[i] & ~gnt_q[i]) wait_q[i] <= sat_inc16(wait_q[i]);
      end
    end
  end

  always_comb begin
    STAT_GRANTS = '0;
    STAT_WAIT   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      STAT_GRANTS[i*16 +: 16] = grants_q[i];
      STAT_WAIT[i*16 +: 16]   = wait_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; read returns are checked by a scoreboard monitor.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic [2:0]   REQ, REQ_WE;
  logic [50:0]  REQ_ADDR;
  logic [95:0]  REQ_WDATA;
  logic [2:0]   GNT, RVALID;
  logic [31:0]  RDATA, MEM_WDATA, MEM_RDATA;
  logic         MEM_EN, MEM_WE, BUSY;
  logic [16:0]  MEM_ADDR;
`ifdef ARB_STATS_EN
  logic [47:0]  STAT_GRANTS, STAT_WAIT;
`endif

  logic [16:0]  addr_v  [3];
  logic [31:0]  wdata_v [3];
  logic [31:0]  mpipe   [2];

  typedef struct { logic [2:0] vec; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign REQ_ADDR  = {addr_v[2], addr_v[1], addr_v[0]};
  assign REQ_WDATA = {wdata_v[2], wdata_v[1], wdata_v[0]};

  always #5 CLK = ~CLK;

  mem_port_arbiter #(
    .N_REQ(3), .ADDR_W(17), .DATA_W(32), .RD_LAT(2), .MAX_BURST(16)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
`ifdef ARB_STATS_EN
    , .STAT_GRANTS(STAT_GRANTS), .STAT_WAIT(STAT_WAIT)
`endif
  );

  function automatic logic [31:0] pattern(input logic [16:0] a);
    return 32'hD000_0000 | {15'h0, a};
  endfunction

  // Memory model: 2-cycle read latency, junk data when no read was issued.
  always @(posedge CLK) begin
    mpipe[1] <= mpipe[0];
    mpipe[0] <= (MEM_EN && !MEM_WE) ? pattern(MEM_ADDR) : 32'hDEAD_BEEF;
  end
  assign MEM_RDATA = mpipe[1];

  function automatic logic [1:0] oh_idx(input logic [2:0] v);
    return v[2] ? 2'd2 : (v[1] ? 2'd1 : 2'd0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RVALID != 3'b000) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid_unexpected: got %b, expected none", RVALID);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_owner", 64'(RVALID), 64'(mon_e.vec));
        chk("rdata", 64'(RDATA), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RSTN = 1'b1;
    REQ = '0;
    REQ_WE = '0;
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b0;
  endtask

  // One cycle: drive requests, check grant/beat at negedge, queue expected read data.
  task automatic run_vec(input logic [2:0] r, input logic [2:0] w, input logic [2:0] eg,
                         input logic ee, input logic crv = 1'b0, input logic [2:0] erv = 3'b000);
    logic [1:0] o;
    REQ = r;
    REQ_WE = w;
    @(negedge CLK);
    chk("gnt", 64'(GNT), 64'(eg));
    chk("mem_en", 64'(MEM_EN), 64'(ee));
    if (ee) begin
      o = oh_idx(eg);
      chk("mem_we", 64'(MEM_WE), 64'(w[o]));
      chk("mem_addr", 64'(MEM_ADDR), 64'(addr_v[o]));
      if (w[o]) chk("mem_wdata", 64'(MEM_WDATA), 64'(wdata_v[o]));
      else sb.push_back('{vec: eg, data: pattern(addr_v[o])});
    end
    if (crv) chk("rvalid", 64'(RVALID), 64'(erv));
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr_v[i]  = 17'h100 + 17'(i);
      wdata_v[i] = 32'hCAFE_0000 + 32'(i);
    end
    reset_dut();

    // Reset state
    @(negedge CLK);
    chk("rst_gnt", 64'(GNT), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_mem_en", 64'(MEM_EN), 64'd0);
    chk("rst_mem_we", 64'(MEM_WE), 64'd0);
    chk("rst_mem_addr", 64'(MEM_ADDR), 64'd0);
    chk("rst_mem_wdata", 64'(MEM_WDATA), 64'd0);
    cyc();

    // Requester 1 reads addresses 5..8
    addr_v[REQ_LD] = 17'd5;
    run_vec(3'b010, 3'b000, 3'b000, 1'b0);
    for (int b = 0; b < 4; b++) begin
      addr_v[REQ_LD] = 17'(5 + b);
      run_vec(3'b010, 3'b000, 3'b010, 1'b1);
    end
    run_vec(3'b000, 3'b000, 3'b010, 1'b0);
    @(negedge CLK);
    chk("t1_gnt_idle", 64'(GNT), 64'd0);
    chk("t1_busy_inflight", 64'(BUSY), 64'd1);
    cyc();
    @(negedge CLK);
    chk("t1_busy_drained", 64'(BUSY), 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    cyc();

    // All three request together: order 0, 1, 2 with an idle cycle after each release
    reset_dut();
    addr_v[REQ_LD] = 17'h101;
    run_vec(3'b111, 3'b111, 3'b000, 1'b0);
    run_vec(3'b111, 3'b111, 3'b001, 1'b1);
    run_vec(3'b111, 3'b111, 3'b001, 1'b1);
    run_vec(3'b110, 3'b111, 3'b001, 1'b0);
    run_vec(3'b110, 3'b111, 3'b000, 1'b0);
    run_vec(3'b110, 3'b111, 3'b010, 1'b1);
    run_vec(3'b110, 3'b111, 3'b010, 1'b1);
    run_vec(3'b100, 3'b111, 3'b010, 1'b0);
    run_vec(3'b100, 3'b111, 3'b000, 1'b0);
    run_vec(3'b100, 3'b111, 3'b100, 1'b1);
    run_vec(3'b100, 3'b111, 3'b100, 1'b1);
    run_vec(3'b000, 3'b111, 3'b100, 1'b0);
    run_vec(3'b000, 3'b111, 3'b000, 1'b0);

    // Burst cap: requester 0 preempted after 16 beats, requester 2 waiting since beat 3
    reset_dut();
    run_vec(3'b001, 3'b111, 3'b000, 1'b0);
    for (int b = 1; b <= 16; b++)
      run_vec((b >= 3) ? 3'b101 : 3'b001, 3'b111, 3'b001, 1'b1);
    run_vec(3'b101, 3'b111, 3'b000, 1'b0);
    for (int b = 0; b < 3; b++) run_vec(3'b101, 3'b111, 3'b100, 1'b1);
    run_vec(3'b001, 3'b111, 3'b100, 1'b0);
    run_vec(3'b001, 3'b111, 3'b000, 1'b0);
    for (int b = 0; b < 24; b++) run_vec(3'b001, 3'b111, 3'b001, 1'b1);
    run_vec(3'b000, 3'b111, 3'b001, 1'b0);
    run_vec(3'b000, 3'b111, 3'b000, 1'b0);

    // Reads from requester 1 still return during requester 2's write beats
    reset_dut();
    addr_v[REQ_LD] = 17'd9;
    run_vec(3'b010, 3'b100, 3'b000, 1'b0);
    for (int b = 0; b < 16; b++) run_vec(3'b110, 3'b100, 3'b010, 1'b1);
    run_vec(3'b100, 3'b100, 3'b000, 1'b0);
    run_vec(3'b100, 3'b100, 3'b100, 1'b1, 1'b1, 3'b010);
    run_vec(3'b100, 3'b100, 3'b100, 1'b1, 1'b1, 3'b000);
    run_vec(3'b000, 3'b100, 3'b100, 1'b0, 1'b1, 3'b000);
    run_vec(3'b000, 3'b100, 3'b000, 1'b0);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with two reads in flight
    reset_dut();
    addr_v[REQ_IF] = 17'h20;
    run_vec(3'b001, 3'b000, 3'b000, 1'b0);
    run_vec(3'b001, 3'b000, 3'b001, 1'b1);
    run_vec(3'b001, 3'b000, 3'b001, 1'b1);
    RSTN = 1'b1;
    sb.delete();
    @(negedge CLK);
    chk("t5_rvalid_in_reset", 64'(RVALID), 64'd0);
    chk("t5_mem_en_in_reset", 64'(MEM_EN), 64'd0);
    cyc();
    RSTN = 1'b0;
    REQ = '0;
    @(negedge CLK);
    chk("t5_gnt_after", 64'(GNT), 64'd0);
    chk("t5_busy_after", 64'(BUSY), 64'd0);
    chk("t5_rvalid_after", 64'(RVALID), 64'd0);
    cyc();
    for (int b = 0; b < 3; b++) run_vec(3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000);

`ifdef ARB_STATS_EN
    reset_dut();
    @(negedge CLK);
    chk("st_rst_grants", 64'(STAT_GRANTS), 64'd0);
    chk("st_rst_wait", 64'(STAT_WAIT), 64'd0);
    cyc();
    run_vec(3'b001, 3'b011, 3'b000, 1'b0);
    run_vec(3'b011, 3'b011, 3'b001, 1'b1);
    run_vec(3'b010, 3'b011, 3'b001, 1'b0);
    run_vec(3'b010, 3'b011, 3'b000, 1'b0);
    for (int b = 0; b < 5; b++) run_vec(3'b010, 3'b011, 3'b010, 1'b1);
    run_vec(3'b000, 3'b011, 3'b010, 1'b0);
    run_vec(3'b000, 3'b011, 3'b000, 1'b0);
    chk("st_wait1", 64'(STAT_WAIT[16 +: 16]), 64'd3);
    chk("st_grants1", 64'(STAT_GRANTS[16 +: 16]), 64'd5);
    chk("st_wait0", 64'(STAT_WAIT[0 +: 16]), 64'd1);
    chk("st_grants0", 64'(STAT_GRANTS[0 +: 16]), 64'd1);
    chk("st_grants2", 64'(STAT_GRANTS[32 +: 16]), 64'd0);
`endif

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
